// File: rtl/vga_arb_pkg.sv
// ============================================================================
// Module      : vga_arb_pkg
// Description : Shared state encoding and default plot-port widths for the
//               vga_adapter write arbiter and the pixel drawers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_arb_pkg;

    localparam int C_X_W      = 8;
    localparam int C_Y_W      = 7;
    localparam int C_COLOUR_W = 3;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_GRANT   = 2'd1;
    localparam state_t S_RELEASE = 2'd2;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
// Module      : arb_pick
// Description : Combinational winner select and one-hot grant vector. Fixed
//               lowest-index priority, or round-robin from a pointer when
//               ARB_ROUND_ROBIN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic             any,
    output logic [IDX_W-1:0] winner,
    output logic [N_REQ-1:0] onehot
);

`ifdef ARB_ROUND_ROBIN_EN
    int w_j;
`endif

    always_comb begin
        any    = |req;
        winner = '0;
`ifdef ARB_ROUND_ROBIN_EN
        w_j    = 0;
        // Walk from the farthest offset down so the first hit after ptr wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_j = int'(ptr) + k;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            if (req[IDX_W'(w_j)]) begin
                winner = IDX_W'(w_j);
            end
        end
`else
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = IDX_W'(i);
            end
        end
`endif
        onehot = any ? (N_REQ'(1) << winner) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/vga_write_arbiter.sv
// ============================================================================
// Module      : vga_write_arbiter
// Description : Grants the single vga_adapter plot port to one drawing unit
//               per pass and forwards its pixels through one register stage.
//               Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_write_arbiter
    import vga_arb_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int X_W      = C_X_W,
    parameter int Y_W      = C_Y_W,
    parameter int COLOUR_W = C_COLOUR_W,
    parameter int CNT_W    = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          pix_valid,
    input  logic [N_REQ-1:0]          pix_last,
    input  logic [N_REQ*X_W-1:0]      pix_x,
    input  logic [N_REQ*Y_W-1:0]      pix_y,
    input  logic [N_REQ*COLOUR_W-1:0] pix_colour,
    output logic [N_REQ-1:0]          gnt,
    output logic [X_W-1:0]            x,
    output logic [Y_W-1:0]            y,
    output logic [COLOUR_W-1:0]       colour,
    output logic                      writeEn,
    output logic                      busy,
    output logic [N_REQ-1:0]          done,
    output logic                      abort,
    output logic [CNT_W-1:0]          pix_count
);

    localparam int IDX_W = idx_width(N_REQ);

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_win, w_win_nxt;
    logic [N_REQ-1:0]    r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0]    r_done, w_done_nxt;
    logic                r_abort, w_abort_nxt;
    logic                w_cnt_clr;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_wen;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_any;
    logic [IDX_W-1:0]    w_pick;
    logic [N_REQ-1:0]    w_onehot;

    logic                w_sel_valid, w_sel_last, w_sel_req, w_fwd;
    logic [X_W-1:0]      w_sel_x;
    logic [Y_W-1:0]      w_sel_y;
    logic [COLOUR_W-1:0] w_sel_colour;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
`endif

    arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
`ifdef ARB_ROUND_ROBIN_EN
        .ptr    (r_ptr),
`endif
        .any    (w_any),
        .winner (w_pick),
        .onehot (w_onehot)
    );

    // Route the latched winner's pixel lane.
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_last   = 1'b0;
        w_sel_req    = 1'b0;
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_colour = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_win == IDX_W'(i)) begin
                w_sel_valid  = pix_valid[i];
                w_sel_last   = pix_last[i];
                w_sel_req    = req[i];
                w_sel_x      = pix_x[i*X_W +: X_W];
                w_sel_y      = pix_y[i*Y_W +: Y_W];
                w_sel_colour = pix_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    assign w_fwd = (r_state == S_GRANT) && w_sel_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_abort_nxt = 1'b0;
        w_cnt_clr   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        w_ptr_nxt   = r_ptr;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                    w_win_nxt   = w_pick;
                    w_gnt_nxt   = w_onehot;
                    w_cnt_clr   = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    w_ptr_nxt   = (w_pick == IDX_W'(N_REQ - 1)) ? '0 : w_pick + IDX_W'(1);
`endif
                end
            end
            S_GRANT: begin
                // A last pixel wins over a simultaneous request drop.
                if (w_fwd && w_sel_last) begin
                    w_done_nxt  = r_gnt;
                    w_gnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end else if (!w_sel_req) begin
                    w_abort_nxt = 1'b1;
                    w_gnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_abort <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_win   <= w_win_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_abort <= w_abort_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr   <= w_ptr_nxt;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wen    <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_cnt    <= '0;
        end else begin
            r_wen <= w_fwd;
            if (w_fwd) begin
                r_x      <= w_sel_x;
                r_y      <= w_sel_y;
                r_colour <= w_sel_colour;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_fwd && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign gnt       = r_gnt;
    assign x         = r_x;
    assign y         = r_y;
    assign colour    = r_colour;
    assign writeEn   = r_wen;
    assign busy      = (r_state == S_GRANT);
    assign done      = r_done;
    assign abort     = r_abort;
    assign pix_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vga_write_arbiter.sv
// ============================================================================
// Module      : tb_vga_write_arbiter
// Description : Directed self-checking bench for vga_write_arbiter, with a
//               second instance at CNT_W=2 for counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_write_arbiter;

    logic        clk;
    logic        reset_n;
    logic [2:0]  req, pix_valid, pix_last;
    logic [23:0] pix_x;
    logic [20:0] pix_y;
    logic [8:0]  pix_colour;

    logic [2:0]  gnt, done;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        writeEn, busy, abort;
    logic [14:0] pix_count;

    logic [2:0]  gnt2, done2;
    logic [7:0]  x2;
    logic [6:0]  y2;
    logic [2:0]  colour2;
    logic        writeEn2, busy2, abort2;
    logic [1:0]  pix_count2;

    int n_checks = 0;
    int n_errors = 0;

    vga_write_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .pix_valid(pix_valid),
        .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
        .gnt(gnt), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
        .busy(busy), .done(done), .abort(abort), .pix_count(pix_count)
    );

    vga_write_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .req(req), .pix_valid(pix_valid),
        .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
        .gnt(gnt2), .x(x2), .y(y2), .colour(colour2), .writeEn(writeEn2),
        .busy(busy2), .done(done2), .abort(abort2), .pix_count(pix_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pix();
        pix_valid  = '0;
        pix_last   = '0;
        pix_x      = '0;
        pix_y      = '0;
        pix_colour = '0;
    endtask

    task automatic set_pix(input int idx, input logic [7:0] px, input logic [6:0] py,
                           input logic [2:0] pc, input logic last);
        clear_pix();
        pix_valid[idx]         = 1'b1;
        pix_last[idx]          = last;
        pix_x[idx*8 +: 8]      = px;
        pix_y[idx*7 +: 7]      = py;
        pix_colour[idx*3 +: 3] = pc;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        clear_pix();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (gnt !== 3'b000 || writeEn !== 1'b0 || busy !== 1'b0 || done !== 3'b000 || abort !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: gnt=%b wen=%b busy=%b done=%b abort=%b, all must be 0", gnt, writeEn, busy, done, abort);
        end
        n_checks++;
        if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0 || pix_count !== 15'd0) begin
            n_errors++;
            $display("FAIL reset_data: x=%0d y=%0d colour=%0d count=%0d, all must be 0", x, y, colour, pix_count);
        end
    endtask

    task automatic test_single_pass();
        do_reset();
        req = 3'b001;
        tick();
        n_checks++;
        if (gnt !== 3'b001 || busy !== 1'b1 || writeEn !== 1'b0) begin
            n_errors++;
            $display("FAIL single_grant: gnt=%b busy=%b wen=%b expected 001 1 0", gnt, busy, writeEn);
        end
        for (int p = 0; p < 4; p++) begin
            set_pix(0, 8'(10 + p), 7'(20 + p), 3'(p + 1), p == 3);
            tick();
            n_checks++;
            if (writeEn !== 1'b1 || x !== 8'(10 + p) || y !== 7'(20 + p) || colour !== 3'(p + 1)) begin
                n_errors++;
                $display("FAIL single_pixel%0d: wen=%b x=%0d y=%0d c=%0d expected 1 %0d %0d %0d",
                         p, writeEn, x, y, colour, 10 + p, 20 + p, p + 1);
            end
        end
        n_checks++;
        if (done !== 3'b001 || gnt !== 3'b000 || busy !== 1'b0 || pix_count !== 15'd4) begin
            n_errors++;
            $display("FAIL single_done: done=%b gnt=%b busy=%b count=%0d expected 001 000 0 4", done, gnt, busy, pix_count);
        end
        clear_pix();
        req = 3'b000;
        tick();
        n_checks++;
        if (done !== 3'b000 || writeEn !== 1'b0 || gnt !== 3'b000 || pix_count !== 15'd4) begin
            n_errors++;
            $display("FAIL single_after: done=%b wen=%b gnt=%b count=%0d expected 000 0 000 4", done, writeEn, gnt, pix_count);
        end
    endtask

    task automatic test_arbitration();
        logic [2:0] exp_g;
        do_reset();
        req = 3'b111;
        tick();
        for (int k = 0; k < 3; k++) begin
            exp_g = 3'b001 << k;
            n_checks++;
            if (gnt !== exp_g) begin
                n_errors++;
                $display("FAIL arb_grant%0d: gnt=%b expected %b", k, gnt, exp_g);
            end
            set_pix(k, 8'(k), 7'(k), 3'(k), 1'b1);
            tick();
            n_checks++;
            if (done !== exp_g || gnt !== 3'b000) begin
                n_errors++;
                $display("FAIL arb_done%0d: done=%b gnt=%b expected %b 000", k, done, gnt, exp_g);
            end
            clear_pix();
            req[k] = 1'b0;
            tick();
            n_checks++;
            if (gnt !== 3'b000) begin
                n_errors++;
                $display("FAIL arb_gap%0d: gnt=%b expected 000", k, gnt);
            end
            tick();
        end
        // Serve 0, then 0 and 2 request again while the port is releasing.
        do_reset();
        req = 3'b001;
        tick();
        set_pix(0, 8'd1, 7'd1, 3'd1, 1'b1);
        tick();
        clear_pix();
        req = 3'b101;
        tick();
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = 3'b100;
`else
        exp_g = 3'b001;
`endif
        n_checks++;
        if (gnt !== exp_g) begin
            n_errors++;
            $display("FAIL arb_rerequest: gnt=%b expected %b", gnt, exp_g);
        end
    endtask

    task automatic test_non_granted();
        do_reset();
        req = 3'b011;
        tick();
        set_pix(0, 8'd5, 7'd6, 3'd2, 1'b0);
        tick();
        set_pix(1, 8'd99, 7'd88, 3'd7, 1'b0);
        tick();
        n_checks++;
        if (writeEn !== 1'b0 || x !== 8'd5 || y !== 7'd6 || colour !== 3'd2 || gnt !== 3'b001 || pix_count !== 15'd1) begin
            n_errors++;
            $display("FAIL non_granted: wen=%b x=%0d y=%0d c=%0d gnt=%b count=%0d expected 0 5 6 2 001 1",
                     writeEn, x, y, colour, gnt, pix_count);
        end
    endtask

    task automatic test_abort();
        do_reset();
        req = 3'b001;
        tick();
        set_pix(0, 8'd1, 7'd1, 3'd1, 1'b0);
        tick();
        set_pix(0, 8'd2, 7'd2, 3'd2, 1'b0);
        tick();
        clear_pix();
        req = 3'b000;
        tick();
        n_checks++;
        if (abort !== 1'b1 || done !== 3'b000 || pix_count !== 15'd2 || gnt !== 3'b000) begin
            n_errors++;
            $display("FAIL abort_pulse: abort=%b done=%b count=%0d gnt=%b expected 1 000 2 000", abort, done, pix_count, gnt);
        end
        tick();
        n_checks++;
        if (abort !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_width: abort=%b expected 0", abort);
        end
    endtask

    task automatic test_last_with_drop();
        do_reset();
        req = 3'b001;
        tick();
        set_pix(0, 8'd7, 7'd7, 3'd7, 1'b1);
        req = 3'b000;
        tick();
        n_checks++;
        if (done !== 3'b001 || abort !== 1'b0 || writeEn !== 1'b1) begin
            n_errors++;
            $display("FAIL last_with_drop: done=%b abort=%b wen=%b expected 001 0 1", done, abort, writeEn);
        end
        clear_pix();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 3'b001;
        tick();
        set_pix(0, 8'd1, 7'd2, 3'd3, 1'b0);
        tick();
        n_checks++;
        if (writeEn !== 1'b1 || gnt !== 3'b001) begin
            n_errors++;
            $display("FAIL areset_pre: wen=%b gnt=%b expected 1 001", writeEn, gnt);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 3'b000 || writeEn !== 1'b0 || busy !== 1'b0 || x !== 8'd0) begin
            n_errors++;
            $display("FAIL areset_drop: gnt=%b wen=%b busy=%b x=%0d expected 000 0 0 0", gnt, writeEn, busy, x);
        end
        req = 3'b000;
        clear_pix();
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || gnt !== 3'b000) begin
            n_errors++;
            $display("FAIL areset_idle: busy=%b gnt=%b expected 0 000", busy, gnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        req = 3'b001;
        tick();
        for (int p = 0; p < 6; p++) begin
            set_pix(0, 8'(p), 7'(p), 3'(p), p == 5);
            tick();
            n_checks++;
            if (writeEn2 !== 1'b1 || x2 !== 8'(p) || pix_count2 !== 2'((p < 3) ? p + 1 : 3)) begin
                n_errors++;
                $display("FAIL sat_pixel%0d: wen=%b x=%0d count=%0d expected 1 %0d %0d",
                         p, writeEn2, x2, pix_count2, p, (p < 3) ? p + 1 : 3);
            end
        end
        n_checks++;
        if (done2 !== 3'b001 || pix_count !== 15'd6) begin
            n_errors++;
            $display("FAIL sat_end: done=%b wide_count=%0d expected 001 6", done2, pix_count);
        end
        clear_pix();
        req = 3'b000;
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        clear_pix();
        test_reset();
        test_single_pass();
        test_arbitration();
        test_non_granted();
        test_abort();
        test_last_with_drop();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
